// File: rtl/branch_issue_ctrl_pkg.sv
// Shared state encoding and constants for the branch issue sequencer.
// The scoreboard id width comes from the codebase-wide SCOREBOARD_SIZE_WIDTH macro.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package branch_issue_ctrl_pkg;

    localparam int unsigned SCB_SID_W = `SCOREBOARD_SIZE_WIDTH;

    localparam logic [3:0] FUNC_JAL  = 4'b0111;
    localparam logic [3:0] FUNC_JALR = 4'b0101;
    localparam logic [3:0] FUNC_BR   = 4'b0100;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StFlush  = 2'd2,
        StBubble = 2'd3
    } bic_state_e;

endpackage

// File: rtl/branch_queue.sv
// In-order FIFO of dispatched branch ops; head fields are read straight from storage.
// Clear drops every entry by snapping the read pointer onto the write pointer.
module branch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SID_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enq,
    input  logic [63:0]      i_enq_pc,
    input  logic [31:0]      i_enq_inst,
    input  logic [SID_W-1:0] i_enq_sid,
    input  logic [3:0]       i_enq_func,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic             o_full,
    output logic             o_empty,
    output logic [63:0]      o_head_pc,
    output logic [31:0]      o_head_inst,
    output logic [SID_W-1:0] o_head_sid,
    output logic [3:0]       o_head_func
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]     r_wr_ptr;
    logic [IDX_W:0]     r_rd_ptr;
    logic [63:0]        r_pc   [DEPTH];
    logic [31:0]        r_inst [DEPTH];
    logic [SID_W-1:0]   r_sid  [DEPTH];
    logic [3:0]         r_func [DEPTH];

    logic               w_do_enq;
    logic               w_do_pop;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) && (w_wr_idx == w_rd_idx);

    assign w_do_enq = i_enq && !o_full;
    assign w_do_pop = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= r_wr_ptr + (IDX_W + 1)'(1);
            end
            // Clear takes priority; the owner never enqueues while clearing.
            if (i_clear) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (IDX_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            r_pc[w_wr_idx]   <= i_enq_pc;
            r_inst[w_wr_idx] <= i_enq_inst;
            r_sid[w_wr_idx]  <= i_enq_sid;
            r_func[w_wr_idx] <= i_enq_func;
        end
    end

    assign o_head_pc   = r_pc[w_rd_idx];
    assign o_head_inst = r_inst[w_rd_idx];
    assign o_head_sid  = r_sid[w_rd_idx];
    assign o_head_func = r_func[w_rd_idx];

endmodule

// File: rtl/branch_issue_ctrl.sv
// Branch issue sequencer: queues dispatched branches, issues the oldest to the BEU when its
// operands are ready, and on redirect flushes younger work and stalls dispatch for a bubble.
module branch_issue_ctrl
    import branch_issue_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned SID_W           = SCB_SID_W,
    parameter int unsigned REDIRECT_BUBBLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  logic [63:0]      enq_pc_i,
    input  logic [31:0]      enq_inst_i,
    input  logic [SID_W-1:0] enq_sid_i,
    input  logic [3:0]       enq_func_code_i,
    output logic [SID_W-1:0] head_sid_o,
    input  logic             opnd_ready_i,
    input  logic [63:0]      rs1_value_i,
    input  logic [63:0]      rs2_value_i,
    output logic             branch_valid_o,
    output logic [63:0]      branch_pc_o,
    output logic [31:0]      branch_inst_o,
    output logic [SID_W-1:0] branch_sid_o,
    output logic [63:0]      rs1_value_o,
    output logic [63:0]      rs2_value_o,
    output logic [3:0]       func_code_o,
    input  logic             branch_redirect_i,
    input  logic [63:0]      branch_redirect_pc_i,
    output logic             resolved_valid_o,
    output logic [SID_W-1:0] resolved_sid_o,
    output logic             resolved_taken_o,
    output logic             redirect_o,
    output logic [63:0]      redirect_pc_o,
    output logic             flush_o,
    output logic [SID_W-1:0] flush_sid_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = (REDIRECT_BUBBLE > 1) ? $clog2(REDIRECT_BUBBLE) : 1;

    bic_state_e         r_state;
    bic_state_e         w_state_next;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic [CNT_W-1:0]   w_bubble_cnt_next;
    logic [SID_W-1:0]   r_issued_sid;
    logic [63:0]        r_redirect_pc;

    logic               w_full;
    logic               w_empty;
    logic [63:0]        w_head_pc;
    logic [31:0]        w_head_inst;
    logic [SID_W-1:0]   w_head_sid;
    logic [3:0]         w_head_func;
    logic               w_issue;
    logic               w_enq;
    logic               w_clear;

    branch_queue #(
        .DEPTH (DEPTH),
        .SID_W (SID_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enq       (w_enq),
        .i_enq_pc    (enq_pc_i),
        .i_enq_inst  (enq_inst_i),
        .i_enq_sid   (enq_sid_i),
        .i_enq_func  (enq_func_code_i),
        .i_pop       (w_issue),
        .i_clear     (w_clear),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_pc   (w_head_pc),
        .o_head_inst (w_head_inst),
        .o_head_sid  (w_head_sid),
        .o_head_func (w_head_func)
    );

    // Dispatch is accepted while idle or waiting on the BEU; held off in reset, flush and bubble.
    assign enq_ready_o = rst_n && !w_full && ((r_state == StIdle) || (r_state == StWait));
    assign w_enq       = enq_valid_i && enq_ready_o;
    assign w_issue     = (r_state == StIdle) && !w_empty && opnd_ready_i;
    assign w_clear     = (r_state == StFlush);
    assign head_sid_o  = w_empty ? '0 : w_head_sid;
    assign busy_o      = !w_empty || (r_state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_bubble_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_bubble_cnt <= w_bubble_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_sid  <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (w_issue) begin
                r_issued_sid <= w_head_sid;
            end
            if ((r_state == StWait) && branch_redirect_i) begin
                r_redirect_pc <= branch_redirect_pc_i;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_bubble_cnt_next = r_bubble_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                w_state_next = branch_redirect_i ? StFlush : StIdle;
            end
            StFlush: begin
                if (REDIRECT_BUBBLE == 0) begin
                    w_state_next = StIdle;
                end else begin
                    w_state_next      = StBubble;
                    w_bubble_cnt_next = CNT_W'(REDIRECT_BUBBLE - 1);
                end
            end
            StBubble: begin
                if (r_bubble_cnt == '0) begin
                    w_state_next = StIdle;
                end else begin
                    w_bubble_cnt_next = r_bubble_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        branch_valid_o   = 1'b0;
        branch_pc_o      = '0;
        branch_inst_o    = '0;
        branch_sid_o     = '0;
        rs1_value_o      = '0;
        rs2_value_o      = '0;
        func_code_o      = '0;
        resolved_valid_o = 1'b0;
        resolved_sid_o   = '0;
        resolved_taken_o = 1'b0;
        redirect_o       = 1'b0;
        redirect_pc_o    = '0;
        flush_o          = 1'b0;
        flush_sid_o      = '0;
        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    branch_valid_o = 1'b1;
                    branch_pc_o    = w_head_pc;
                    branch_inst_o  = w_head_inst;
                    branch_sid_o   = w_head_sid;
                    rs1_value_o    = rs1_value_i;
                    rs2_value_o    = rs2_value_i;
                    func_code_o    = w_head_func;
                end
            end
            StWait: begin
                resolved_valid_o = 1'b1;
                resolved_sid_o   = r_issued_sid;
                resolved_taken_o = branch_redirect_i;
            end
            StFlush: begin
                redirect_o    = 1'b1;
                redirect_pc_o = r_redirect_pc;
                flush_o       = 1'b1;
                flush_sid_o   = r_issued_sid;
            end
            StBubble: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/branch_issue_ctrl.md
# branch_issue_ctrl

Sequencer in front of the branch execution unit. Buffers dispatched branch/jump ops in order, issues the oldest one to the BEU once the scoreboard reports its operands ready, and waits for resolution. On a redirect it flushes all younger queued branches, pulses redirect/flush to the front end and scoreboard, and holds off new work for a fixed bubble. One branch is in flight at a time.

## Interface

- DEPTH, 4, queue entries; power of two, ≥2
- SID_W, `SCOREBOARD_SIZE_WIDTH, scoreboard id width
- REDIRECT_BUBBLE, 2, cycles enqueue stays blocked after the flush pulse; 0 allowed
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- enq_valid_i / enq_ready_o  in/out  1  dispatch handshake; transfer when both high
- enq_pc_i  in  64, enq_inst_i  in  32, enq_sid_i  in  SID_W, enq_func_code_i  in  4  dispatched op
- head_sid_o  out  SID_W  sid of queue head, for scoreboard operand lookup
- opnd_ready_i  in  1  head operands available this cycle
- rs1_value_i, rs2_value_i  in  64  head operand values, valid with opnd_ready_i
- branch_valid_o  out  1, branch_pc_o  64, branch_inst_o  32, branch_sid_o  SID_W, rs1_value_o/rs2_value_o  64, func_code_o  4  issue to BEU
- branch_redirect_i  in  1, branch_redirect_pc_i  in  64  BEU result, one cycle after issue
- resolved_valid_o  out  1, resolved_sid_o  out  SID_W, resolved_taken_o  out  1  completion to scoreboard
- redirect_o  out  1, redirect_pc_o  out  64  front-end redirect pulse
- flush_o  out  1, flush_sid_o  out  SID_W  kill everything younger than flush_sid_o
- busy_o  out  1  queue non-empty or state ≠ IDLE

## Operation

- Queue: circular FIFO, rd/wr pointers log2(DEPTH)+1 bits; full when low bits equal and MSBs differ, empty when pointers equal. No bypass: an entry enqueued in cycle T is issuable at T+1 earliest.
- enq_ready_o = !full && state ∈ {IDLE, WAIT}. Simultaneous enq+issue in IDLE keeps count constant; a full queue still refuses enq that cycle.
- States:
  - IDLE: if !empty && opnd_ready_i → branch_valid_o=1 with head fields and rs values, pop, → WAIT. Else stay.
  - WAIT: resolved_valid_o=1, resolved_sid_o=issued sid, resolved_taken_o=branch_redirect_i. If branch_redirect_i → latch pc and sid, → FLUSH; else → IDLE. No issue in WAIT.
  - FLUSH: redirect_o=1, redirect_pc_o=latched pc, flush_o=1, flush_sid_o=issued sid, single cycle. Queue cleared at end of cycle (rd_ptr←wr_ptr), including entries accepted during WAIT. → BUBBLE, or IDLE if REDIRECT_BUBBLE=0.
  - BUBBLE: down-counter loaded with REDIRECT_BUBBLE−1; → IDLE when it reaches 0.
- branch_redirect_i outside WAIT is ignored.
- Outputs not named active in a state are 0 (data outputs may hold don't-care but are driven to 0 when their valid is low).

## Timing

- Reset: state IDLE, pointers 0, counter 0; every output 0, enq_ready_o 0 during reset, 1 in first cycle after release.
- Issue→resolve: 1 cycle (BEU registers inputs, redirect combinational from that register). Peak throughput: one branch per 2 cycles.
- Redirect: issue T, resolve/redirect_i T+1, redirect_o/flush_o T+2, enq blocked T+2..T+2+REDIRECT_BUBBLE, first new enq T+3+REDIRECT_BUBBLE.
- Issue outputs combinational from registered head + state + opnd_ready_i; redirect_o/flush_o from registered state.
- Reset mid-operation: in-flight branch and queue discarded, no pulses emitted.

## Structure

- Shared package: state encoding (IDLE/WAIT/FLUSH/BUBBLE), func codes JAL=4'b0111, JALR=4'b0101, BR=4'b0100, SID_W from `SCOREBOARD_SIZE_WIDTH.
- Sub-module: branch_queue (parameterised FIFO with enq, pop, clear, full/empty, head fields). FSM and bubble counter in top.

## Test plan

- Reset then single not-taken BEQ, sid 3, opnd_ready at once → branch_valid_o next cycle, resolved_valid_o sid 3 taken 0 one cycle later, no flush, busy_o drops.
- Enqueue 4 branches back-to-back (DEPTH=4) → 5th refused (enq_ready_o 0), issues spaced 2 cycles in sid order 0,1,2,3.
- Head JAL sid 5 with two queued behind, BEU redirects to 0x8000_1000 → redirect_o/flush_o one cycle with pc 0x8000_1000, flush_sid 5, queue empty, enq blocked exactly 2 cycles.
- opnd_ready_i low for 3 cycles on head → no issue, head_sid_o stable; issues cycle ready rises.
- Enqueue during WAIT of a redirecting branch → entry flushed, never issued; REDIRECT_BUBBLE=0 build returns to IDLE right after FLUSH.
- Pointer wrap: 10 not-taken branches through DEPTH=4 → all issued in order, full/empty correct across wrap; spurious branch_redirect_i in IDLE ignored.
